// File: rtl/fetch_if2icb_ob_if.sv
// Handshake bundle between the IFU, the fetch bridge and the instruction ICB port.
// The "slave" view belongs to the bridge; the "master" view is the surrounding
// IFU + memory environment that drives requests and bus responses.
interface fetch_if2icb_ob_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
);
  // IFU request channel
  logic                   if_req_valid;
  logic                   if_req_ready;
  logic [PC_WIDTH-1:0]    if_req_pc;
  // IFU response channel
  logic                   if_resp_valid;
  logic                   if_resp_ready;
  logic                   if_resp_err;
  logic [INSTR_WIDTH-1:0] if_resp_instr;
  // ICB command channel
  logic                   icb_cmd_valid;
  logic                   icb_cmd_ready;
  logic [PC_WIDTH-1:0]    icb_cmd_addr;
  logic                   icb_cmd_read;
  // ICB response channel
  logic                   icb_rsp_valid;
  logic                   icb_rsp_ready;
  logic                   icb_rsp_err;
  logic [INSTR_WIDTH-1:0] icb_rsp_rdata;

  modport slave (
    input  if_req_valid, if_req_pc, if_resp_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    output if_req_ready, if_resp_valid, if_resp_err, if_resp_instr,
           icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_rsp_ready
  );

  modport master (
    output if_req_valid, if_req_pc, if_resp_ready,
           icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata,
    input  if_req_ready, if_resp_valid, if_resp_err, if_resp_instr,
           icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_rsp_ready
  );
endinterface

// File: rtl/fetch_if2icb_ob.sv
// IF-to-ICB fetch bridge with up to OUTS_DEPTH in-order outstanding fetches.
// A ring buffer of slots holds each fetch from command issue until the IFU takes
// the instruction; three pointers track issue (wr), bus return (fill) and IFU
// consumption (rd). A flush abandons everything in flight and counts how many bus
// responses still have to come back so they can be swallowed silently.
// Note: rst_n is an active-HIGH asynchronous reset; the name is historical.
module fetch_if2icb_ob #(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int OUTS_DEPTH  = 2,
  parameter int ALIGN_LSB   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  fetch_if2icb_ob_if.slave bus
);

  localparam int IDX_W = $clog2(OUTS_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
    ~((PC_WIDTH'(1) << ALIGN_LSB) - PC_WIDTH'(1));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       fill_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       drop_cnt;
  logic [OUTS_DEPTH-1:0]  slot_filled;
  logic                   slot_err  [OUTS_DEPTH];
  logic [INSTR_WIDTH-1:0] slot_data [OUTS_DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [PTR_W:0]   used;
  logic [PTR_W-1:0] unreturned;
  logic             credit;
  logic             idle;
  logic             misaligned;
  logic             req_ready;
  logic             cmd_valid;
  logic             req_fire;
  logic             resp_valid;
  logic             resp_fire;
  logic             rsp_drop;
  logic             rsp_accept;
  logic [PTR_W-1:0] drop_after_flush;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign fill_idx = fill_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];

  // Occupancy counts both live slots and abandoned fetches still owed by the bus,
  // so new commands cannot overrun the response space the bus relies on.
  assign used       = {1'b0, wr_ptr - rd_ptr} + {1'b0, drop_cnt};
  assign credit     = used < (PTR_W+1)'(OUTS_DEPTH);
  assign idle       = (used == '0);
  assign unreturned = wr_ptr - fill_ptr;

  generate
    if (ALIGN_LSB > 0) begin : g_align
      assign misaligned = |bus.if_req_pc[ALIGN_LSB-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // Request acceptance and command issue; misaligned PCs never reach the bus and
  // wait until the bridge is empty so their error stays in program order.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else leaves it unassigned and no latch is inferred.
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    if (!rst_n && !flush) begin
      if (misaligned) begin
        req_ready = idle;
      end else begin
        cmd_valid = bus.if_req_valid & credit;
        req_ready = bus.icb_cmd_ready & credit;
      end
    end
  end

  assign req_fire = bus.if_req_valid & req_ready;

  // Bus responses: first pay off abandoned fetches, otherwise fill the oldest
  // unreturned slot. A response with nothing outstanding is ignored.
  assign rsp_drop   = bus.icb_rsp_valid & (drop_cnt != '0);
  assign rsp_accept = bus.icb_rsp_valid & (drop_cnt == '0) & (fill_ptr != wr_ptr);

  // A flush turns every unreturned bus fetch into a pending drop; a response
  // consumed in the flush cycle itself (dropped or filled) is no longer owed.
  assign drop_after_flush = drop_cnt + unreturned
                          - ((rsp_drop | rsp_accept) ? PTR_W'(1) : PTR_W'(0));

  assign resp_valid = slot_filled[rd_idx] & (rd_ptr != wr_ptr) & ~flush & ~rst_n;
  assign resp_fire  = resp_valid & bus.if_resp_ready;

  assign bus.if_req_ready  = req_ready;
  assign bus.icb_cmd_valid = cmd_valid;
  assign bus.icb_cmd_addr  = bus.if_req_pc & ALIGN_MASK;
  assign bus.icb_cmd_read  = 1'b1;
  assign bus.icb_rsp_ready = 1'b1;
  assign bus.if_resp_valid = resp_valid;
  assign bus.if_resp_err   = resp_valid & slot_err[rd_idx];
  assign bus.if_resp_instr = resp_valid ? slot_data[rd_idx] : '0;

  // Pointer, drop counter and slot-valid bookkeeping.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_n) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (flush) begin
      rd_ptr      <= wr_ptr;
      fill_ptr    <= wr_ptr;
      slot_filled <= '0;
      drop_cnt    <= drop_after_flush;
    end else begin
      // The three updates touch distinct slots: wr and fill only alias rd when
      // the ring is full or rd's slot is still unfilled.
      if (req_fire) begin
        wr_ptr              <= wr_ptr + PTR_W'(1);
        slot_filled[wr_idx] <= misaligned;
        // A misaligned entry needs no bus data, so fill moves past it too.
        if (misaligned) fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - PTR_W'(1);
      if (rsp_accept) begin
        slot_filled[fill_idx] <= 1'b1;
        fill_ptr              <= fill_ptr + PTR_W'(1);
      end
      if (resp_fire) begin
        slot_filled[rd_idx] <= 1'b0;
        rd_ptr              <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Slot payload storage; contents only matter while the slot's filled bit is set.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; validity lives in slot_filled, which
    // is reset, so clearing the data would only cost reset routing.
    if (req_fire && misaligned) begin
      slot_err[wr_idx]  <= 1'b1;
      slot_data[wr_idx] <= '0;
    end
    if (rsp_accept) begin
      slot_err[fill_idx]  <= bus.icb_rsp_err;
      slot_data[fill_idx] <= bus.icb_rsp_rdata;
    end
  end

  // The bus must never answer a fetch that was not issued.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst_n)
    !(bus.icb_rsp_valid && drop_cnt == '0 && fill_ptr == wr_ptr));

endmodule

// File: tb/tb_fetch_if2icb_ob.sv
// Directed bench for the IF-to-ICB fetch bridge (OUTS_DEPTH=2, ALIGN_LSB=2).
// Each vector is one clock: inputs are driven at the falling edge, outputs are
// compared 1ns later, and the rising edge then applies the cycle's handshakes.
module tb_fetch_if2icb_ob;

  typedef struct packed {
    logic        rv;    // if_req_valid
    logic [31:0] pc;    // if_req_pc
    logic        cr;    // icb_cmd_ready
    logic        sv;    // icb_rsp_valid
    logic        se;    // icb_rsp_err
    logic [31:0] sd;    // icb_rsp_rdata
    logic        rr;    // if_resp_ready
    logic        fl;    // flush
    logic        e_rq;  // expected if_req_ready
    logic        e_cv;  // expected icb_cmd_valid
    logic        e_pv;  // expected if_resp_valid
    logic        e_pe;  // expected if_resp_err (checked when valid)
    logic [31:0] e_pi;  // expected if_resp_instr (checked when valid)
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   errors;
  vec_t tbl[$];
  vec_t hv;

  fetch_if2icb_ob_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_if2icb_ob #(
    .PC_WIDTH(32), .INSTR_WIDTH(32), .OUTS_DEPTH(2), .ALIGN_LSB(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rv, input logic [31:0] pc, input logic cr,
                              input logic sv, input logic se, input logic [31:0] sd,
                              input logic rr, input logic fl,
                              input logic e_rq, input logic e_cv, input logic e_pv,
                              input logic e_pe, input logic [31:0] e_pi);
    vec_t v;
    v.rv = rv; v.pc = pc; v.cr = cr; v.sv = sv; v.se = se; v.sd = sd;
    v.rr = rr; v.fl = fl;
    v.e_rq = e_rq; v.e_cv = e_cv; v.e_pv = e_pv; v.e_pe = e_pe; v.e_pi = e_pi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.if_req_valid  = v.rv;
    bus.if_req_pc     = v.pc;
    bus.icb_cmd_ready = v.cr;
    bus.icb_rsp_valid = v.sv;
    bus.icb_rsp_err   = v.se;
    bus.icb_rsp_rdata = v.sd;
    bus.if_resp_ready = v.rr;
    flush             = v.fl;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] exp_addr;
    @(negedge clk);
    drive(v);
    #1;
    exp_addr = v.pc & 32'hFFFF_FFFC;
    check({tag, "_req_ready"}, 32'(bus.if_req_ready), 32'(v.e_rq));
    check({tag, "_cmd_valid"}, 32'(bus.icb_cmd_valid), 32'(v.e_cv));
    check({tag, "_cmd_addr"}, bus.icb_cmd_addr, exp_addr);
    check({tag, "_resp_valid"}, 32'(bus.if_resp_valid), 32'(v.e_pv));
    if (v.e_pv) begin
      check({tag, "_resp_err"}, 32'(bus.if_resp_err), 32'(v.e_pe));
      check({tag, "_resp_instr"}, bus.if_resp_instr, v.e_pi);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state: a pending aligned request must not leak through while in reset.
    rst_n = 1'b1;
    drive(mk(1, 32'h40, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    check("rst_req_ready", 32'(bus.if_req_ready), 32'd0);
    check("rst_cmd_valid", 32'(bus.icb_cmd_valid), 32'd0);
    check("rst_resp_valid", 32'(bus.if_resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.if_resp_err), 32'd0);
    check("cmd_read_const", 32'(bus.icb_cmd_read), 32'd1);
    check("rsp_ready_const", 32'(bus.icb_rsp_ready), 32'd1);
    @(negedge clk);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;

    // T1: single fetch, command stalled one cycle by the bus, response 2 cycles later.
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h100, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 1, 0, 32'h13, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 32'h13));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    // T2: back-to-back fills both credits, third request waits for a consume.
    tbl.push_back(mk(1, 32'h100, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h104, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h108, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h108, 1, 1, 0, 32'hAAAA0001, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h108, 1, 1, 0, 32'hAAAA0002, 0, 0,  0, 0, 1, 0, 32'hAAAA0001));
    tbl.push_back(mk(1, 32'h108, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'hAAAA0001));
    tbl.push_back(mk(1, 32'h108, 1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 32'hAAAA0001));
    tbl.push_back(mk(1, 32'h108, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 32'hAAAA0002));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 32'hAAAA0002));
    tbl.push_back(mk(0, 32'h0,   1, 1, 0, 32'hAAAA0003, 1, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 32'hAAAA0003));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    // T3: misaligned 0x102 held behind a pending fetch, then errors without a command.
    tbl.push_back(mk(1, 32'h110, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h102, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h102, 1, 1, 0, 32'h111, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h102, 1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 32'h111));
    tbl.push_back(mk(1, 32'h102, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    // Misaligned by the lowest bit, issued from idle.
    tbl.push_back(mk(1, 32'h501, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 1, 32'h0));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));
    // T5: bus error passes through with its data; the next fetch is clean.
    tbl.push_back(mk(1, 32'h300, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 32'h304, 1, 1, 1, 32'hDEAD0300, 0, 0,  1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   1, 1, 0, 32'h00C0FFEE, 1, 0,  0, 0, 1, 1, 32'hDEAD0300));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 32'h00C0FFEE));
    tbl.push_back(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("v%0d", i));

    // T4a: flush while a response is visible and ready is high; it is discarded.
    run_vec(mk(1, 32'h11C, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0), "fa0");
    run_vec(mk(0, 32'h0,   1, 1, 0, 32'h11C, 0, 0,  1, 0, 0, 0, 0), "fa1");
    run_vec(mk(0, 32'h0,   1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0), "fa2");
    run_vec(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0), "fa3");
    // T4b: flush with two outstanding; both late responses vanish, 0x200 gets its own data.
    run_vec(mk(1, 32'h120, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0), "fb0");
    run_vec(mk(1, 32'h124, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0), "fb1");
    run_vec(mk(1, 32'h200, 1, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0), "fb2");
    run_vec(mk(1, 32'h200, 1, 1, 0, 32'hBAD1, 1, 0,  0, 0, 0, 0, 0), "fb3");
    run_vec(mk(1, 32'h200, 1, 1, 0, 32'hBAD2, 1, 0,  1, 1, 0, 0, 0), "fb4");
    run_vec(mk(0, 32'h0,   1, 1, 0, 32'h200, 1, 0,  1, 0, 0, 0, 0), "fb5");
    run_vec(mk(0, 32'h0,   1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 32'h200), "fb6");
    run_vec(mk(0, 32'h0,   1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0), "fb7");

    // T6: reset with one buffered (0x130) and one outstanding (0x134) fetch.
    run_vec(mk(1, 32'h130, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0), "r0");
    run_vec(mk(1, 32'h134, 1, 1, 0, 32'h130, 0, 0,  1, 1, 0, 0, 0), "r1");
    hv = mk(1, 32'h0, 1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h130);
    run_vec(hv, "r2");
    #1 rst_n = 1'b1;
    #1;
    check("r3_req_ready", 32'(bus.if_req_ready), 32'd0);
    check("r3_resp_valid", 32'(bus.if_resp_valid), 32'd0);
    check("r3_resp_err", 32'(bus.if_resp_err), 32'd0);
    check("r3_cmd_valid", 32'(bus.icb_cmd_valid), 32'd0);
    @(negedge clk);
    #1;
    check("r4_req_ready", 32'(bus.if_req_ready), 32'd0);
    check("r4_cmd_valid", 32'(bus.icb_cmd_valid), 32'd0);
    check("r4_resp_valid", 32'(bus.if_resp_valid), 32'd0);
    drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    run_vec(mk(1, 32'h0, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0), "r5");
    run_vec(mk(0, 32'h0, 1, 1, 0, 32'h93, 0, 0,  1, 0, 0, 0, 0), "r6");
    run_vec(mk(0, 32'h0, 1, 0, 0, 0, 1, 0,  1, 0, 1, 0, 32'h93), "r7");
    run_vec(mk(0, 32'h0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0), "r8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
